// File: rtl/simd_array_pkg.sv
// simd_array_pkg
// Shared definitions for the SIMD ALU: element width, lane count, bus width
// and the opcode enumeration. The same opcode enum is reused by the
// instruction decoder for instr_info_t.op.
package simd_array_pkg;

  // Width of one packed element.
  localparam int USIZE = 16;
  // Elements carried by one bus word.
  localparam int LANES = 5;
  // Full operand/result bus width.
  localparam int BUS_W = LANES * USIZE;

  // Lane operation selector. SIMD_RSV always produces zero.
  typedef enum logic [1:0] {
    SIMD_ADD = 2'd0,
    SIMD_SUB = 2'd1,
    SIMD_MUL = 2'd2,
    SIMD_RSV = 2'd3
  } simd_op_t;

endpackage

// File: rtl/simd_array_lane.sv
// simd_lane
// Combinational arithmetic for a single SIMD element. Results wrap modulo
// 2^USIZE; signed and unsigned operands give identical low bits, so there
// is no signedness control.
// Ports:
//   a   in  USIZE      operand A element
//   b   in  USIZE      operand B element
//   op  in  simd_op_t  operation selector
//   y   out USIZE      element result
module simd_lane
  import simd_array_pkg::*;
#(
  parameter int USIZE = simd_array_pkg::USIZE
) (
  input  logic [USIZE-1:0] a,
  input  logic [USIZE-1:0] b,
  input  simd_op_t         op,
  output logic [USIZE-1:0] y
);

  // The default arm also catches an unknown selector in simulation, so the
  // reserved/unknown case never lets X reach the result register.
  always_comb begin
    y = '0;
    case (op)
      SIMD_ADD: y = a + b;
      SIMD_SUB: y = a - b;
      SIMD_MUL: y = a * b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/simd_array.sv
// simd_array
// Lane-parallel SIMD ALU used as the compute core of each proc worker.
// One opcode is applied to LANES packed elements of two bus-wide operands
// and the lane results are registered, giving exactly one cycle of latency
// with no handshake.
// Ports:
//   i_clk   in  1      clock, rising edge
//   i_rstn  in  1      asynchronous active-low reset
//   i_in1   in  BUS_W  operand A, LANES packed elements (lane 0 = MSB slice)
//   i_in2   in  BUS_W  operand B, LANES packed elements
//   opcode  in  2      0=add, 1=sub, 2=mul, 3=reserved (result 0)
//   o_res   out BUS_W  registered lane-wise result
module simd_array
  import simd_array_pkg::*;
#(
  parameter int USIZE = simd_array_pkg::USIZE,
  parameter int LANES = simd_array_pkg::LANES,
  parameter int BUS_W = LANES * USIZE
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [BUS_W-1:0] i_in1,
  input  logic [BUS_W-1:0] i_in2,
  input  logic [1:0]       opcode,
  output logic [BUS_W-1:0] o_res
);

  simd_op_t         op_sel;
  logic [BUS_W-1:0] lane_res;

  assign op_sel = simd_op_t'(opcode);

  // Lane k sits at the k-th slice counted down from the MSB, so lane 0 is
  // the most significant element. Lanes are fully independent: no carry or
  // borrow crosses a slice boundary.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    simd_lane #(
      .USIZE(USIZE)
    ) u_lane (
      .a  (i_in1[BUS_W-1-k*USIZE -: USIZE]),
      .b  (i_in2[BUS_W-1-k*USIZE -: USIZE]),
      .op (op_sel),
      .y  (lane_res[BUS_W-1-k*USIZE -: USIZE])
    );
  end

  // Single result register; reset discards any in-flight result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_res <= '0;
    end else begin
      o_res <= lane_res;
    end
  end

endmodule

// File: tb/tb_simd_array.sv
// tb_simd_array
// Self-checking bench for simd_array: directed cases with hand-derived
// results, plus randomized operands checked against a lane-by-lane
// arithmetic reference.
module tb_simd_array;

  localparam int USIZE = 16;
  localparam int LANES = 5;
  localparam int BUS_W = LANES * USIZE;

  logic             clk;
  logic             rstn;
  logic [BUS_W-1:0] in1;
  logic [BUS_W-1:0] in2;
  logic [1:0]       opcode;
  logic [BUS_W-1:0] res;

  int total = 0;
  int bad   = 0;

  simd_array dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_in1  (in1),
    .i_in2  (in2),
    .opcode (opcode),
    .o_res  (res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane 0 is the most significant slice.
  function automatic logic [BUS_W-1:0] pack(input logic [15:0] l0, l1, l2, l3, l4);
    return {l0, l1, l2, l3, l4};
  endfunction

  // Reference: unpack each lane with plain arithmetic, compute modulo 2^16.
  function automatic logic [BUS_W-1:0] model(input logic [BUS_W-1:0] a,
                                             input logic [BUS_W-1:0] b,
                                             input int op);
    logic [BUS_W-1:0] out;
    longint x, y, r;
    out = '0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'(a[BUS_W-1-k*USIZE -: USIZE]);
      y = longint'(b[BUS_W-1-k*USIZE -: USIZE]);
      case (op)
        0:       r = x + y;
        1:       r = x - y;
        2:       r = x * y;
        default: r = 0;
      endcase
      r = r % 65536;
      if (r < 0) r = r + 65536;
      out[BUS_W-1-k*USIZE -: USIZE] = 16'(r);
    end
    return out;
  endfunction

  task automatic checkOutput(input string tag,
                             input logic [BUS_W-1:0] got,
                             input logic [BUS_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive a new operand set on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic [BUS_W-1:0] a,
                               input logic [BUS_W-1:0] b,
                               input logic [1:0] op);
    @(negedge clk);
    in1    = a;
    in2    = b;
    opcode = op;
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS_W-1:0] rnd_bus();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  logic [BUS_W-1:0] a_r, b_r, prev;
  logic [1:0]       op_r;

  initial begin
    rstn   = 1'b1;
    in1    = rnd_bus();
    in2    = rnd_bus();
    opcode = 2'd0;

    // Async reset before any clock edge.
    #2 rstn = 1'b0;
    #1 checkOutput("reset_async", res, '0);

    // Random inputs while held in reset: output stays zero across edges.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rnd_bus(), rnd_bus(), 2'($urandom_range(0, 2)));
      waitEdge();
      checkOutput("reset_hold", res, '0);
    end

    // Release between edges: still zero until the first edge.
    applyStimulus(pack(16'd1, 16'd2, 16'd3, 16'd4, 16'd5),
                  pack(16'd10, 16'd20, 16'd30, 16'd40, 16'd50), 2'd0);
    rstn = 1'b1;
    #1 checkOutput("release_pre_edge", res, '0);
    waitEdge();
    checkOutput("add_basic", res, pack(16'd11, 16'd22, 16'd33, 16'd44, 16'd55));

    // Lane wrap with no carry into the neighbour (lane 1 = 1+1).
    applyStimulus(pack(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h8000),
                  pack(16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'h8000), 2'd0);
    waitEdge();
    checkOutput("add_wrap", res, pack(16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000));

    applyStimulus(pack(16'h5, 16'h0, 16'h8000, 16'hFFFF, 16'h7),
                  pack(16'h3, 16'h1, 16'h0001, 16'hFFFF, 16'h7), 2'd1);
    waitEdge();
    checkOutput("sub", res, pack(16'h2, 16'hFFFF, 16'h7FFF, 16'h0, 16'h0));

    applyStimulus(pack(16'd0, 16'd3, 16'd4, 16'd5, 16'd0),
                  pack(16'd6, 16'd7, 16'd0, 16'd0, 16'd0), 2'd2);
    waitEdge();
    checkOutput("mul", res, pack(16'd0, 16'd21, 16'd0, 16'd0, 16'd0));

    applyStimulus(pack(16'h0003, 16'h0100, 16'hFFFF, 16'h00FF, 16'h1234),
                  pack(16'h0005, 16'h0100, 16'hFFFF, 16'h0101, 16'h0010), 2'd2);
    waitEdge();
    checkOutput("mul_trunc", res, pack(16'h000F, 16'h0000, 16'h0001, 16'hFFFF, 16'h2340));

    // Hold operands, step the opcode each cycle; before each edge the
    // previous result must still be present.
    a_r  = pack(16'h0009, 16'h0100, 16'h0002, 16'hFFFF, 16'h0000);
    b_r  = pack(16'h0004, 16'h0003, 16'h0005, 16'h0002, 16'h0007);
    prev = res;
    for (int op = 0; op < 4; op++) begin
      applyStimulus(a_r, b_r, 2'(op));
      #1 checkOutput($sformatf("latency_op%0d", op), res, prev);
      waitEdge();
      case (op)
        0: checkOutput("switch_add", res, pack(16'h000D, 16'h0103, 16'h0007, 16'h0001, 16'h0007));
        1: checkOutput("switch_sub", res, pack(16'h0005, 16'h00FD, 16'hFFFD, 16'hFFFD, 16'hFFF9));
        2: checkOutput("switch_mul", res, pack(16'h0024, 16'h0300, 16'h000A, 16'hFFFE, 16'h0000));
        default: checkOutput("switch_rsv", res, '0);
      endcase
      prev = res;
    end

    // Holding inputs holds the result.
    applyStimulus(a_r, b_r, 2'd1);
    waitEdge();
    waitEdge();
    checkOutput("hold_steady", res, model(a_r, b_r, 1));

    // Async reset in the middle of a stream.
    applyStimulus(a_r, b_r, 2'd2);
    waitEdge();
    checkOutput("pre_midreset", res, model(a_r, b_r, 2));
    #2 rstn = 1'b0;
    #1 checkOutput("midreset_drop", res, '0);
    waitEdge();
    checkOutput("midreset_hold", res, '0);
    applyStimulus(a_r, b_r, 2'd0);
    rstn = 1'b1;
    #1 checkOutput("midreset_release", res, '0);
    waitEdge();
    checkOutput("midreset_resume", res, model(a_r, b_r, 0));

    // Randomized operands and opcodes against the reference.
    for (int i = 0; i < 300; i++) begin
      a_r  = rnd_bus();
      b_r  = rnd_bus();
      op_r = 2'($urandom_range(0, 3));
      applyStimulus(a_r, b_r, op_r);
      waitEdge();
      checkOutput($sformatf("rand%0d_op%0d", i, op_r), res, model(a_r, b_r, int'(op_r)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
